// File: rtl/aes_pkg.sv
// Shared definitions for the AES job arbiter: FSM encodings, requester
// count and per-mode key / data word counts.
package aes_pkg;

  localparam int unsigned AES_NREQ = 4;

  // FSM encodings
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ARB      = 3'd1;
  localparam logic [2:0] ST_KEY_LD   = 3'd2;
  localparam logic [2:0] ST_KEY_WAIT = 3'd3;
  localparam logic [2:0] ST_DATA_LD  = 3'd4;
  localparam logic [2:0] ST_RUN      = 3'd5;
  localparam logic [2:0] ST_RESULT   = 3'd6;

  // Key words to load for each 2-bit AES mode
  localparam logic [3:0] AES_KEY_WORDS_M0 = 4'd4;
  localparam logic [3:0] AES_KEY_WORDS_M1 = 4'd4;
  localparam logic [3:0] AES_KEY_WORDS_M2 = 4'd6;
  localparam logic [3:0] AES_KEY_WORDS_M3 = 4'd8;

  // Data words per job, and the ceiling of the word counter
  localparam logic [3:0] AES_DATA_WORDS = 4'd4;
  localparam logic [3:0] AES_CNT_MAX    = 4'd8;

  function automatic logic [3:0] key_words(input logic [1:0] mode);
    logic [3:0] n;
    case (mode)
      2'b00:   n = AES_KEY_WORDS_M0;
      2'b01:   n = AES_KEY_WORDS_M1;
      2'b10:   n = AES_KEY_WORDS_M2;
      default: n = AES_KEY_WORDS_M3;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/aes_rr_arbiter.sv
// Round-robin pick among 4 requesters: the search starts at ptr_i and
// wraps; the first active request found wins (one-hot, or zero if none).
module aes_rr_arbiter
  import aes_pkg::*;
(
  input  logic [AES_NREQ-1:0] req_i,
  input  logic [1:0]          ptr_i,
  output logic [AES_NREQ-1:0] gnt_o
);

  logic [1:0] idx;

  // Walk offsets from farthest to nearest so the nearest active request wins
  always_comb begin
    gnt_o = '0;
    idx   = ptr_i;
    for (int k = AES_NREQ - 1; k >= 0; k--) begin
      idx = ptr_i + 2'(k);
      if (req_i[idx]) gnt_o = 4'b0001 << idx;
    end
  end

endmodule

// File: rtl/aes_job_arbiter.sv
// Arbitrates 4 requesters onto one AES core: grants a job, loads the key
// (skipped when the cached key already matches), loads 4 data words, starts
// the core, and hands the result back. Word handshake: a word moves on a
// rising edge where AJA_I_WORD_VLD and AJA_O_WORD_RDY are both high; RDY does
// not depend on VLD, and drops as soon as the phase has its last word.
module aes_job_arbiter
  import aes_pkg::*;
#(
  parameter int unsigned AJA_P_TIMEOUT = 255
) (
  input  logic       AJA_I_CLK,
  input  logic       AJA_I_RST,
  input  logic [3:0] AJA_I_REQ,
  input  logic [3:0] AJA_I_KEY_CHG,
  input  logic [7:0] AJA_I_MODE,
  input  logic [3:0] AJA_I_E_D,
  input  logic       AJA_I_WORD_VLD,
  output logic       AJA_O_WORD_RDY,
  output logic [3:0] AJA_O_GNT,
  output logic       AJA_O_D_K,
  output logic [1:0] AJA_O_AES_MODE,
  output logic       AJA_O_E_D,
  output logic [3:0] AJA_O_COUNT_IO,
  output logic       AJA_O_START,
  input  logic       AJA_I_KSA_DONE,
  input  logic       AJA_I_DATA_DONE,
  output logic       AJA_O_RESULT_VLD,
  input  logic       AJA_I_RESULT_ACK,
  output logic       AJA_O_ERR,
  output logic [2:0] AJA_O_STATE
);

  localparam int unsigned    WW        = $clog2(AJA_P_TIMEOUT + 1);
  localparam logic [WW-1:0]  WAIT_LAST = WW'(AJA_P_TIMEOUT - 1);
  localparam logic [WW-1:0]  WAIT_ONE  = WW'(1);

  logic [2:0]    state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    owner_q, owner_d;
  logic [1:0]    mode_q, mode_d;
  logic          ed_q, ed_d;
  logic          kchg_q, kchg_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [1:0]    ptr_q, ptr_d;
  logic          err_q, err_d;
  logic          cache_vld_q, cache_vld_d;
  logic [1:0]    cache_owner_q, cache_owner_d;
  logic [1:0]    cache_mode_q, cache_mode_d;
  logic          cache_ed_q, cache_ed_d;

  logic [3:0] win;
  logic [1:0] win_idx;
  logic [3:0] need;
  logic [3:0] cnt_inc;
  logic       word_rdy;
  logic       xfer;
  logic       owner_req;
  logic       wait_exp;
  logic       key_hit;

  aes_rr_arbiter u_rr (
    .req_i (AJA_I_REQ),
    .ptr_i (ptr_q),
    .gnt_o (win)
  );

  assign win_idx   = onehot_idx(win);
  assign need      = key_words(mode_q);
  assign cnt_inc   = (cnt_q == AES_CNT_MAX) ? cnt_q : cnt_q + 4'd1;
  assign owner_req = AJA_I_REQ[owner_q];
  assign wait_exp  = (wait_q == WAIT_LAST);
  assign key_hit   = cache_vld_q && (cache_owner_q == owner_q) && !kchg_q &&
                     (cache_mode_q == mode_q) && (cache_ed_q == ed_q);

  // Ready is purely state/count based so the requester never sees it depend on VLD
  always_comb begin
    word_rdy = 1'b0;
    if (state_q == ST_KEY_LD)  word_rdy = (cnt_q < need);
    if (state_q == ST_DATA_LD) word_rdy = (cnt_q < AES_DATA_WORDS);
  end

  assign xfer = AJA_I_WORD_VLD & word_rdy;

  // Job sequencing, key-cache bookkeeping and timeout handling
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    owner_d       = owner_q;
    mode_d        = mode_q;
    ed_d          = ed_q;
    kchg_d        = kchg_q;
    cnt_d         = cnt_q;
    wait_d        = wait_q;
    ptr_d         = ptr_q;
    err_d         = 1'b0;
    cache_vld_d   = cache_vld_q;
    cache_owner_d = cache_owner_q;
    cache_mode_d  = cache_mode_q;
    cache_ed_d    = cache_ed_q;

    case (state_q)
      ST_IDLE: begin
        if (|AJA_I_REQ) begin
          // Grant is registered here so it is visible in the ARB cycle
          state_d = ST_ARB;
          gnt_d   = win;
          owner_d = win_idx;
          mode_d  = AJA_I_MODE[{win_idx, 1'b0} +: 2];
          ed_d    = AJA_I_E_D[win_idx];
          kchg_d  = AJA_I_KEY_CHG[win_idx];
          ptr_d   = win_idx + 2'd1;
          cnt_d   = 4'd0;
        end
      end

      ST_ARB: begin
        cnt_d   = 4'd0;
        state_d = key_hit ? ST_DATA_LD : ST_KEY_LD;
      end

      ST_KEY_LD: begin
        if (!owner_req) begin
          // Partial key in the core is unusable: forget the cached key
          state_d     = ST_IDLE;
          gnt_d       = 4'd0;
          cache_vld_d = 1'b0;
        end else if (xfer) begin
          cnt_d = cnt_inc;
          if (cnt_inc == need) begin
            state_d = ST_KEY_WAIT;
            wait_d  = '0;
          end
        end
      end

      ST_KEY_WAIT: begin
        if (AJA_I_KSA_DONE) begin
          cache_vld_d   = 1'b1;
          cache_owner_d = owner_q;
          cache_mode_d  = mode_q;
          cache_ed_d    = ed_q;
          cnt_d         = 4'd0;
          state_d       = ST_DATA_LD;
        end else if (wait_exp) begin
          err_d       = 1'b1;
          cache_vld_d = 1'b0;
          gnt_d       = 4'd0;
          state_d     = ST_IDLE;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end

      ST_DATA_LD: begin
        if (!owner_req) begin
          state_d = ST_IDLE;
          gnt_d   = 4'd0;
        end else if (xfer) begin
          cnt_d = cnt_inc;
          if (cnt_inc == AES_DATA_WORDS) begin
            state_d = ST_RUN;
            wait_d  = '0;
          end
        end
      end

      ST_RUN: begin
        if (AJA_I_DATA_DONE) begin
          state_d = ST_RESULT;
        end else if (wait_exp) begin
          err_d       = 1'b1;
          cache_vld_d = 1'b0;
          gnt_d       = 4'd0;
          state_d     = ST_IDLE;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end

      ST_RESULT: begin
        if (AJA_I_RESULT_ACK) begin
          gnt_d   = 4'd0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        gnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any job in flight immediately
  always_ff @(posedge AJA_I_CLK or negedge AJA_I_RST) begin
    if (!AJA_I_RST) begin
      state_q       <= ST_IDLE;
      gnt_q         <= 4'd0;
      owner_q       <= 2'd0;
      mode_q        <= 2'd0;
      ed_q          <= 1'b0;
      kchg_q        <= 1'b0;
      cnt_q         <= 4'd0;
      wait_q        <= '0;
      ptr_q         <= 2'd0;
      err_q         <= 1'b0;
      cache_vld_q   <= 1'b0;
      cache_owner_q <= 2'd0;
      cache_mode_q  <= 2'd0;
      cache_ed_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      owner_q       <= owner_d;
      mode_q        <= mode_d;
      ed_q          <= ed_d;
      kchg_q        <= kchg_d;
      cnt_q         <= cnt_d;
      wait_q        <= wait_d;
      ptr_q         <= ptr_d;
      err_q         <= err_d;
      cache_vld_q   <= cache_vld_d;
      cache_owner_q <= cache_owner_d;
      cache_mode_q  <= cache_mode_d;
      cache_ed_q    <= cache_ed_d;
    end
  end

  assign AJA_O_WORD_RDY   = word_rdy;
  assign AJA_O_GNT        = gnt_q;
  assign AJA_O_D_K        = (state_q == ST_DATA_LD) || (state_q == ST_RUN) ||
                            (state_q == ST_RESULT);
  assign AJA_O_AES_MODE   = mode_q;
  assign AJA_O_E_D        = ed_q;
  assign AJA_O_COUNT_IO   = cnt_q;
  assign AJA_O_START      = (state_q == ST_RUN);
  assign AJA_O_RESULT_VLD = (state_q == ST_RESULT);
  assign AJA_O_ERR        = err_q;
  assign AJA_O_STATE      = state_q;

endmodule
